// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the compare unit.
//   - cmp_op_e    : operation codes seen on the op input (6 and 7 are reserved)
//   - CMP_OP_W    : width of the op field
//   - CMP_RES_BIT : bit of the result word that carries the boolean
package cmp_pkg;

  localparam int CMP_OP_W    = 3;
  localparam int CMP_RES_BIT = 0;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_EQ   = 3'd0,
    CMP_NE   = 3'd1,
    CMP_LT   = 3'd2,
    CMP_GE   = 3'd3,
    CMP_LTU  = 3'd4,
    CMP_GEU  = 3'd5,
    CMP_RSV6 = 3'd6,
    CMP_RSV7 = 3'd7
  } cmp_op_e;

endpackage

// File: rtl/cmp_eval.sv
// cmp_eval: combinational evaluation of one compare operation.
// Ports:
//   a_i, b_i  [WIDTH-1:0]     operands
//   op_i      [CMP_OP_W-1:0]  operation code
//   res_o                     boolean result (0 for reserved ops)
//   err_o                     1 when op_i is a reserved code
module cmp_eval
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [CMP_OP_W-1:0] op_i,
  output logic                res_o,
  output logic                err_o
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;

  // GE/GEU are defined as the exact complements of LT/LTU.
  always_comb begin
    res_o = 1'b0;
    err_o = 1'b0;
    case (cmp_op_e'(op_i))
      CMP_EQ:  res_o = (a_i == b_i);
      CMP_NE:  res_o = (a_i != b_i);
      CMP_LT:  res_o = lt_s;
      CMP_GE:  res_o = !lt_s;
      CMP_LTU: res_o = lt_u;
      CMP_GEU: res_o = !lt_u;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_unit.sv
// cmp_unit: two-stage pipelined comparator with valid/ready handshakes and a
// saturating count of delivered true results.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   A, B [WIDTH-1:0]         operands
//   op [2:0]                 operation code (see cmp_pkg::cmp_op_e)
//   in_valid / in_ready      input handshake
//   R [RWIDTH-1:0]           zero-extended boolean result
//   err                      result came from a reserved op
//   out_valid / out_ready    output handshake
//   cnt_clr                  synchronous clear of true_cnt
//   true_cnt [CNTW-1:0]      saturating count of delivered results with R[0]=1
//
// Handshake: a transfer occurs on a rising edge where valid && ready. Valid is
// never withdrawn and data never changes while valid is high and ready is low;
// in_ready depends only on registers and out_ready, never on in_valid.
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RWIDTH = 16,
  parameter int CNTW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [CMP_OP_W-1:0] op,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [RWIDTH-1:0]   R,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cnt_clr,
  output logic [CNTW-1:0]     true_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Stage 1: captured operands.
  logic                s1_v_q,  s1_v_d;
  logic [WIDTH-1:0]    s1_a_q,  s1_a_d;
  logic [WIDTH-1:0]    s1_b_q,  s1_b_d;
  logic [CMP_OP_W-1:0] s1_op_q, s1_op_d;

  // Stage 2: evaluated result.
  logic                s2_v_q,  s2_v_d;
  logic                res_q,   res_d;
  logic                err_q,   err_d;

  logic [CNTW-1:0]     cnt_q,   cnt_d;

  logic s2_adv;
  logic s1_adv;
  logic out_xfer;
  logic eval_res;
  logic eval_err;

  cmp_eval #(
    .WIDTH (WIDTH)
  ) u_eval (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .res_o (eval_res),
    .err_o (eval_err)
  );

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_v_q && out_ready;

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    s2_v_d  = s2_v_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d  = A;
        s1_b_d  = B;
        s1_op_d = op;
      end
    end

    // Bubbles load zeros so R/err stay clean while out_valid is low.
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      res_d  = s1_v_q && eval_res;
      err_d  = s1_v_q && eval_err;
    end

    // Clear wins over a same-cycle counted transfer.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && res_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
      s2_v_q  <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_op_q <= s1_op_d;
      s2_v_q  <= s2_v_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    R              = '0;
    R[CMP_RES_BIT] = res_q;
  end

  assign err       = err_q;
  assign out_valid = s2_v_q;
  assign true_cnt  = cnt_q;

endmodule
